universal_shift_reg: RTL and testbench

- Parametrised WIDTH-bit register bank with true and complementary outputs.
- Per-cycle operation selected by MODE: hold, parallel load, logical shift left/right with serial inputs, rotate left/right, synchronous clear, bitwise invert.
- Registered zero flag and serial-out taps.
- General-purpose storage and shifting element for the lab datapaths: serialisers, LED chasers, operand registers.

---
 rtl/usr_pkg.sv | 13 +
 rtl/usr_next_state.sv | 37 +++
 rtl/universal_shift_reg.sv | 80 ++++++++
 tb/tb_universal_shift_reg.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared operation encodings for the universal shift register and its controllers.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_INV  = 3'b111;

endpackage : usr_pkg

// File: rtl/usr_next_state.sv
// Combinational next-value logic for the universal shift register.
module usr_next_state
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] q_next,
    output logic             zero_next
);

    // Select the new register value for the requested operation
    always_comb begin
        q_next = q;
        case (mode)
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = d;
            MODE_SHL:  q_next = {q[WIDTH-2:0], sil};
            MODE_SHR:  q_next = {sir, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_CLR:  q_next = {WIDTH{1'b0}};
            MODE_INV:  q_next = ~q;
            default:   q_next = q;
        endcase
    end

    // Zero flag is derived from the new value so it registers alongside Q
    always_comb begin
        zero_next = (q_next == {WIDTH{1'b0}});
    end

endmodule : usr_next_state

// File: rtl/universal_shift_reg.sv
// Universal shift register: Q, QN and ZERO registered together; SOL/SOR tap Q.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             SOL,
    output logic             SOR,
    output logic             ZERO
);

    localparam logic RST_ZERO = (RST_VAL == {WIDTH{1'b0}});

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] qn_q;
    logic [WIDTH-1:0] qn_d;
    logic             zero_q;
    logic             zero_d;
    logic [WIDTH-1:0] q_next_s;
    logic             zero_next_s;

    usr_next_state #(
        .WIDTH (WIDTH)
    ) u_next (
        .q         (q_q),
        .mode      (MODE),
        .d         (D),
        .sil       (SIL),
        .sir       (SIR),
        .q_next    (q_next_s),
        .zero_next (zero_next_s)
    );

    // Enable gating; QN comes from the pre-edge next value, never from updated Q
    always_comb begin
        q_d    = q_q;
        qn_d   = qn_q;
        zero_d = zero_q;
        if (EN) begin
            q_d    = q_next_s;
            qn_d   = ~q_next_s;
            zero_d = zero_next_s;
        end else begin
            q_d    = q_q;
            qn_d   = qn_q;
            zero_d = zero_q;
        end
    end

    // State registers with asynchronous reset to RST_VAL
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q    <= RST_VAL;
            qn_q   <= ~RST_VAL;
            zero_q <= RST_ZERO;
        end else begin
            q_q    <= q_d;
            qn_q   <= qn_d;
            zero_q <= zero_d;
        end
    end

    assign Q    = q_q;
    assign QN   = qn_q;
    assign ZERO = zero_q;
    assign SOL  = q_q[WIDTH-1];
    assign SOR  = q_q[0];

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
// Directed and randomised self-checking bench for universal_shift_reg (WIDTH=8, RST_VAL=8'hA5).
module tb_universal_shift_reg;
    import usr_pkg::*;

    localparam int         W    = 8;
    localparam logic [7:0] RSTV = 8'hA5;

    logic         CLK = 1'b0;
    logic         RST;
    logic         EN;
    logic [2:0]   MODE;
    logic [W-1:0] D;
    logic         SIL;
    logic         SIR;
    logic [W-1:0] Q;
    logic [W-1:0] QN;
    logic         SOL;
    logic         SOR;
    logic         ZERO;

    int total = 0;
    int bad   = 0;

    universal_shift_reg #(
        .WIDTH   (W),
        .RST_VAL (RSTV)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .MODE (MODE),
        .D    (D),
        .SIL  (SIL),
        .SIR  (SIR),
        .Q    (Q),
        .QN   (QN),
        .SOL  (SOL),
        .SOR  (SOR),
        .ZERO (ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] exp);
        chk({tag, ".Q"},    {56'd0, Q},    {56'd0, exp});
        chk({tag, ".QN"},   {56'd0, QN},   {56'd0, ~exp});
        chk({tag, ".ZERO"}, {63'd0, ZERO}, {63'd0, (exp == 8'h00)});
        chk({tag, ".SOL"},  {63'd0, SOL},  {63'd0, exp[7]});
        chk({tag, ".SOR"},  {63'd0, SOR},  {63'd0, exp[0]});
    endtask

    function automatic logic [7:0] model(input logic [7:0] q, input logic en, input logic [2:0] m,
                                         input logic [7:0] d, input logic sl, input logic sr);
        logic [7:0] r;
        r = q;
        if (en) begin
            case (m)
                3'd1:    r = d;
                3'd2:    r = (q << 1) | {7'd0, sl};
                3'd3:    r = (q >> 1) | {sr, 7'd0};
                3'd4:    r = (q << 1) | (q >> 7);
                3'd5:    r = (q >> 1) | (q << 7);
                3'd6:    r = 8'h00;
                3'd7:    r = q ^ 8'hFF;
                default: r = q;
            endcase
        end
        return r;
    endfunction

    initial begin
        logic [7:0] exp_q;

        RST = 1'b1; EN = 1'b0; MODE = MODE_HOLD; D = 8'h00; SIL = 1'b0; SIR = 1'b0;
        #2;
        chk_all("reset_async", 8'hA5);
        step(2);
        chk_all("reset_held", 8'hA5);
        RST = 1'b0;

        EN = 1'b1; MODE = MODE_LOAD; D = 8'h00;
        step(1);
        chk_all("load_zero", 8'h00);

        MODE = MODE_SHL; SIL = 1'b1;
        step(3);
        chk_all("shl_fill3", 8'h07);

        MODE = MODE_SHR; SIR = 1'b0;
        step(1);
        chk_all("shr_once", 8'h03);

        MODE = MODE_LOAD; D = 8'h81;
        step(1);
        MODE = MODE_ROL;
        step(1);
        chk_all("rol_81", 8'h03);
        MODE = MODE_ROR;
        step(1);
        chk_all("ror_1", 8'h81);
        step(1);
        chk_all("ror_2", 8'hC0);
        step(7);
        chk_all("ror_9", 8'h81);
        step(8);
        chk_all("ror_17", 8'h81);

        MODE = MODE_LOAD; D = 8'h3C;
        step(1);
        EN = 1'b0; MODE = MODE_CLR; D = 8'hFF;
        step(5);
        chk_all("en_gate", 8'h3C);
        EN = 1'b1;
        step(1);
        chk_all("clr", 8'h00);

        MODE = MODE_LOAD; D = 8'hF0;
        step(1);
        MODE = MODE_INV;
        step(1);
        chk_all("inv_1", 8'h0F);
        step(1);
        chk_all("inv_2", 8'hF0);
        MODE = MODE_HOLD; D = 8'h12;
        step(1);
        chk_all("hold", 8'hF0);
        MODE = MODE_SHR; SIR = 1'b1;
        step(1);
        chk_all("shr_sir1", 8'hF8);
        MODE = MODE_SHL; SIL = 1'b0;
        step(1);
        chk_all("shl_drop", 8'hF0);

        MODE = MODE_LOAD; D = 8'h01;
        step(1);
        MODE = MODE_SHL; SIL = 1'b1;
        step(1);
        chk_all("shl_stream", 8'h03);
        #3;
        RST = 1'b1;
        #1;
        chk_all("rst_mid_shift", 8'hA5);
        step(1);
        chk_all("rst_dominates", 8'hA5);
        #3;
        RST = 1'b0; SIL = 1'b0;
        step(1);
        chk_all("post_rst_shl", 8'h4A);

        exp_q = 8'h4A;
        for (int i = 0; i < 1000; i++) begin
            EN   = ($urandom_range(0, 7) != 0);
            MODE = 3'($urandom_range(0, 7));
            D    = 8'($urandom_range(0, 255));
            SIL  = 1'($urandom_range(0, 1));
            SIR  = 1'($urandom_range(0, 1));
            exp_q = model(exp_q, EN, MODE, D, SIL, SIR);
            step(1);
            chk_all("random", exp_q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_universal_shift_reg
